piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 53 +++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with valid/ready word intake and a stallable bit stream
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic last, load;
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    in_ready = state == IDLE || (last && ser_en);
    load = in_valid && in_ready;
    state_nx = state;
    sreg_nx = sreg;
    cnt_nx = cnt;
    if (load) begin
      state_nx = SHIFT;
      sreg_nx = in_data;
      cnt_nx = '0;
    end else if (state == SHIFT && ser_en) begin
      state_nx = last ? IDLE : SHIFT;
      sreg_nx = last ? '0 : (MSB_FIRST ? sreg << 1 : sreg >> 1);
      cnt_nx = last ? '0 : cnt + 1'b1;
    end
  end
  // outputs derive from held state, so a stall freezes them and IDLE forces zeros
  assign ser_valid = state == SHIFT;
  assign ser_out = ser_valid && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign ser_last = ser_valid && last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      sreg <= sreg_nx;
      cnt <= cnt_nx;
    end
endmodule
